// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: self-synchronising receiver for the 16-bit generator sequence.
// Hunts for a legal seed, verifies LOCK_CNT consecutive predictions, then flywheels
// the prediction while locked and counts mismatches until LOSS_THRESH in a row.
//
// Input handshake: in_valid qualifies in_data for one cycle and the word is consumed
// on that rising edge; there is no ready/backpressure, so the checker must accept a
// word on every clock. Cycles with in_valid=0 leave all state untouched.
module lfsr_seq_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [MR_W-1:0] LOCK_VAL = MR_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] LOSS_VAL = MS_W'(LOSS_THRESH);

  // Generator step function; must stay bit-identical to the transmit side.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic f;
    f = q[15];
    return {q[14:5], q[4] ^ f, q[3], q[2] ^ f, q[1] ^ f, q[0], f};
  endfunction

  state_t           r_state;
  logic [15:0]      r_expected;
  logic [MR_W-1:0]  r_match_run;
  logic [MS_W-1:0]  r_miss_run;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_err_pulse;

  state_t           w_state_nxt;
  logic [15:0]      w_expected_nxt;
  logic [MR_W-1:0]  w_match_run_nxt;
  logic [MS_W-1:0]  w_miss_run_nxt;
  logic             w_err_ev;
  logic             w_word_ev;

  logic [15:0]      w_step_data;
  logic [15:0]      w_step_exp;
  logic             w_match;
  logic [MR_W-1:0]  w_match_inc;
  logic [MS_W-1:0]  w_miss_inc;

  assign w_step_data = lfsr_step(in_data);
  assign w_step_exp  = lfsr_step(r_expected);
  assign w_match     = (in_data == r_expected);
  assign w_match_inc = r_match_run + MR_W'(1);
  assign w_miss_inc  = r_miss_run + MS_W'(1);

  // Next-state, prediction update and counter events for the consumed word.
  always_comb begin
    w_state_nxt     = r_state;
    w_expected_nxt  = r_expected;
    w_match_run_nxt = r_match_run;
    w_miss_run_nxt  = r_miss_run;
    w_err_ev        = 1'b0;
    w_word_ev       = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_VERIFY: begin
          if (w_match) begin
            w_expected_nxt  = w_step_exp;
            w_match_run_nxt = w_match_inc;
            if (w_match_inc == LOCK_VAL) begin
              w_state_nxt    = ST_LOCKED;
              w_miss_run_nxt = '0;
            end
          end else if (in_data != 16'h0000) begin
            // Re-seed from the received word and restart the confidence run.
            w_expected_nxt  = w_step_data;
            w_match_run_nxt = '0;
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction advances on its own; data never reseeds here.
          w_expected_nxt = w_step_exp;
          w_word_ev      = 1'b1;
          if (w_match) begin
            w_miss_run_nxt = '0;
          end else begin
            w_err_ev       = 1'b1;
            w_miss_run_nxt = w_miss_inc;
            if (w_miss_inc == LOSS_VAL) begin
              w_state_nxt = ST_HUNT;
            end
          end
        end
        default: begin
          // HUNT, and the unused encoding which behaves as HUNT.
          // All-zero is the LFSR lock-up value and can never seed the sequence.
          if (in_data != 16'h0000) begin
            w_expected_nxt  = w_step_data;
            w_match_run_nxt = '0;
            w_state_nxt     = ST_VERIFY;
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end
      endcase
    end
  end

  // State register plus prediction and run-length trackers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_HUNT;
      r_expected  <= 16'hFFFF;
      r_match_run <= '0;
      r_miss_run  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_match_run <= w_match_run_nxt;
      r_miss_run  <= w_miss_run_nxt;
    end
  end

  // Saturating counters; a clear wins over an increment and drops that event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err_ev;
      if (clr_cnt) begin
        r_err_cnt  <= '0;
        r_word_cnt <= '0;
      end else begin
        if (w_err_ev && (r_err_cnt != {CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
        if (w_word_ev && (r_word_cnt != {CNT_W{1'b1}})) begin
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign word_cnt  = r_word_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: a table of {inputs, expected outputs} records plus
// hand-written sequences for async reset and VERIFY re-seeding. Expectations go into
// a queue when a word is driven and are compared one cycle later after the edge.
module tb_lfsr_seq_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] word_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        c;
    logic [1:0]  st;
    logic        p;
    logic [15:0] e;
    logic [15:0] w;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] seq[0:31];
  logic [35:0] exp_q[$];
  int          tag_q[$];

  lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_THRESH(3), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .word_cnt (word_cnt),
    .state    (state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Generator written as a left-shifting Galois register with tap mask 0x002D.
  function automatic logic [15:0] bstep(input logic [15:0] q);
    return {q[14:0], 1'b0} ^ (q[15] ? 16'h002D : 16'h0000);
  endfunction

  function automatic logic [35:0] pk(input logic [1:0] st, input logic p,
                                     input logic [15:0] e, input logic [15:0] w);
    return {st, p, (st == 2'd2), e, w};
  endfunction

  function automatic logic [35:0] outs();
    return {state, err_pulse, locked, err_cnt, word_cnt};
  endfunction

  task automatic add(input logic v, input logic [15:0] d, input logic c,
                     input logic [1:0] st, input logic p,
                     input logic [15:0] e, input logic [15:0] w);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.st = st; r.p = p; r.e = e; r.w = w;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got st=%0d pulse=%0b locked=%0b err=%0d words=%0d, want st=%0d pulse=%0b locked=%0b err=%0d words=%0d",
               name, got[35:34], got[33], got[32], got[31:16], got[15:0],
               want[35:34], want[33], want[32], want[31:16], want[15:0]);
    end
  endtask

  // Driver: present one word at the falling edge and queue its expected result.
  task automatic step(input logic v, input logic [15:0] d, input logic c,
                      input logic [35:0] e, input int tag);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h0000;
    clr_cnt  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare shortly after the edge that consumed the word.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [35:0] e;
      int          t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check($sformatf("vec%0d", t), outs(), e);
    end
  end

  initial begin
    logic [15:0] w_word;

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    clr_cnt  = 1'b0;

    seq[0] = 16'hFFFF;
    for (int i = 1; i < 32; i++) seq[i] = bstep(seq[i-1]);

    // Lock from reset: first word enters VERIFY, fifth word locks.
    for (int i = 0; i < 4; i++) add(1'b1, seq[i], 1'b0, 2'd1, 1'b0, 16'd0, 16'd0);
    add(1'b1, seq[4], 1'b0, 2'd2, 1'b0, 16'd0, 16'd0);
    // Single corrupted word while locked, then flywheel matches.
    add(1'b1, seq[5], 1'b0, 2'd2, 1'b0, 16'd0, 16'd1);
    add(1'b1, seq[6] ^ 16'h0001, 1'b0, 2'd2, 1'b1, 16'd1, 16'd2);
    add(1'b1, seq[7], 1'b0, 2'd2, 1'b0, 16'd1, 16'd3);
    add(1'b1, seq[8], 1'b0, 2'd2, 1'b0, 16'd1, 16'd4);
    // Idle cycle changes nothing; idle clear zeroes both counters.
    add(1'b0, 16'h0000, 1'b0, 2'd2, 1'b0, 16'd1, 16'd4);
    add(1'b0, 16'h0000, 1'b1, 2'd2, 1'b0, 16'd0, 16'd0);
    // Three consecutive mismatches force re-hunt.
    add(1'b1, seq[9]  ^ 16'h0001, 1'b0, 2'd2, 1'b1, 16'd1, 16'd1);
    add(1'b1, seq[10] ^ 16'h0001, 1'b0, 2'd2, 1'b1, 16'd2, 16'd2);
    add(1'b1, seq[11] ^ 16'h0001, 1'b0, 2'd0, 1'b1, 16'd3, 16'd3);
    // Lock-up value never seeds.
    for (int i = 0; i < 4; i++) add(1'b1, 16'h0000, 1'b0, 2'd0, 1'b0, 16'd3, 16'd3);
    // Clean restart re-locks after five words.
    for (int i = 0; i < 4; i++) add(1'b1, seq[i], 1'b0, 2'd1, 1'b0, 16'd3, 16'd3);
    add(1'b1, seq[4], 1'b0, 2'd2, 1'b0, 16'd3, 16'd3);
    // Clear on the same edge as a locked mismatch: counters 0, pulse still fires.
    add(1'b1, seq[5] ^ 16'h0001, 1'b1, 2'd2, 1'b1, 16'd0, 16'd0);
    add(1'b1, seq[6], 1'b0, 2'd2, 1'b0, 16'd0, 16'd1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_state", outs(), 36'd0);
    rst = 1'b1;

    foreach (tbl[i]) step(tbl[i].v, tbl[i].d, tbl[i].c,
                          pk(tbl[i].st, tbl[i].p, tbl[i].e, tbl[i].w), i);
    go_idle();

    // Mid-stream reset: outputs clear before any further clock edge.
    check("pre_rst_locked", {35'd0, locked}, 36'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = seq[7];
    rst      = 1'b0;
    #1;
    check("async_rst", outs(), 36'd0);
    step(1'b1, seq[8], 1'b0, pk(2'd0, 1'b0, 16'd0, 16'd0), 200);
    go_idle();
    @(negedge clk);
    rst = 1'b1;

    // VERIFY re-seed: two matches, then off-sequence W, then lock from S(W).
    step(1'b1, seq[0], 1'b0, pk(2'd1, 1'b0, 16'd0, 16'd0), 300);
    step(1'b1, seq[1], 1'b0, pk(2'd1, 1'b0, 16'd0, 16'd0), 301);
    step(1'b1, seq[2], 1'b0, pk(2'd1, 1'b0, 16'd0, 16'd0), 302);
    w_word = 16'h1234;
    step(1'b1, w_word, 1'b0, pk(2'd1, 1'b0, 16'd0, 16'd0), 303);
    for (int i = 0; i < 3; i++) begin
      w_word = bstep(w_word);
      step(1'b1, w_word, 1'b0, pk(2'd1, 1'b0, 16'd0, 16'd0), 304 + i);
    end
    w_word = bstep(w_word);
    step(1'b1, w_word, 1'b0, pk(2'd2, 1'b0, 16'd0, 16'd0), 307);
    w_word = bstep(w_word);
    step(1'b1, w_word, 1'b0, pk(2'd2, 1'b0, 16'd0, 16'd1), 308);
    // Zero word in VERIFY returns to HUNT.
    go_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, seq[3], 1'b0, pk(2'd1, 1'b0, 16'd0, 16'd0), 400);
    step(1'b1, 16'h0000, 1'b0, pk(2'd0, 1'b0, 16'd0, 16'd0), 401);
    go_idle();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
